ch8_mem_arbiter: RTL
====================

CH8_MEM_ARBITER -- requirements
Module: ch8_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM address width (4096 bytes).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter LOCK_TO, default 16, idle-owner cycles before a lock is forcibly released.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  3  access request per requester: [0]=loader, [1]=CPU, [2]=draw engine.
REQ-007 lock  input  3  per requester; holds ownership after the granted access.
REQ-008 we  input  3  per requester; 1=write, 0=read.
REQ-009 addr  input  3*ADDR_W  per-requester address, requester k at bits [k*ADDR_W +: ADDR_W].
REQ-010 wdata  input  3*DATA_W  per-requester write data, same packing.
REQ-011 gnt  output  3  one-hot access grant, combinational, same cycle as accepted req.
REQ-012 rvalid  output  3  one-hot, read data valid for requester k.
REQ-013 rdata  output  DATA_W  read data, shared by all requesters.
REQ-014 ram_en, ram_we  output  1 each  RAM command strobes.
REQ-015 ram_addr / ram_wdata  output  ADDR_W / DATA_W  RAM command fields.
REQ-016 ram_rdata  input  DATA_W  synchronous RAM read data, one-cycle latency.
REQ-017 lock_err  output  1  sticky flag, set on forced lock release.

Function
REQ-018 SHALL grant at most one requester per cycle; gnt[k] implies req[k].
REQ-019 In cycle with gnt[k]: ram_en=1, ram_we=we[k], ram_addr/ram_wdata = requester k fields; otherwise ram_en=0, ram_we=0.
REQ-020 Access completes in the grant cycle; requester may present a new access the next cycle; one access per cycle maximum throughput.
REQ-021 Read granted in cycle T SHALL give rvalid[k]=1 in T+1 only, with rdata=ram_rdata; writes produce no rvalid.
REQ-022 FSM states: IDLE, LOCKED(owner).
REQ-023 IDLE priority: loader first; between CPU and draw, round-robin pointer; pointer resets to CPU and moves to the other requester after each CPU or draw grant.
REQ-024 IDLE -> LOCKED(owner=k) when gnt[k] and lock[k]=1.
REQ-025 LOCKED: only owner may be granted, loader included; other requests stall.
REQ-026 LOCKED -> IDLE when owner is granted with lock=0; that grant itself is serviced.
REQ-027 LOCKED: idle counter increments each cycle owner has req=0, clears on owner req=1; at LOCK_TO consecutive idle cycles -> IDLE, lock_err<=1, counter cleared.
REQ-028 In the cycle a forced release occurs no grant is issued; arbitration resumes next cycle.
REQ-029 lock_err SHALL remain set until reset.
REQ-030 Round-robin pointer SHALL not update on loader grants.
REQ-031 Simultaneous req on all three in IDLE SHALL grant loader.

Reset
REQ-032 On rst_n=0: FSM=IDLE, rr pointer=CPU, idle counter=0, rvalid=0, lock_err=0; gnt=0 and ram_en=0 while rst_n=0.
REQ-033 Reset during LOCKED or with a read outstanding SHALL drop the lock and suppress the pending rvalid.

Structure
REQ-034 Package ch8_pkg SHALL hold ADDR_W/DATA_W defaults, requester indices REQ_LOAD=0, REQ_CPU=1, REQ_DRAW=2, and the FSM state encoding.
REQ-035 Single module, no sub-modules; the round-robin pick is internal logic.

Verification
REQ-036 CPU and draw hold req continuously, reads -> grants alternate CPU,draw,CPU...; each rvalid one cycle after its grant with the matching ram_rdata.
REQ-037 All three req in IDLE -> loader granted; loader drops req -> CPU granted (pointer still at CPU).
REQ-038 CPU reads 0x200 with lock=1, then reads 0x201 with lock=0 while loader requests -> CPU, CPU, then loader granted.
REQ-039 Draw locks, then drops req for 16 cycles -> on cycle 16 FSM returns to IDLE, lock_err=1, CPU granted the following cycle.
REQ-040 Loader writes 0xA5 to 0x050 -> ram_en=1, ram_we=1, ram_addr=0x050, ram_wdata=0xA5; no rvalid.
REQ-041 rst_n asserted one cycle after a locked CPU read grant -> no rvalid, FSM IDLE, draw grant available once rst_n releases.

Source files
------------

// File: rtl/ch8_pkg.sv
// ch8_pkg: shared constants for the CHIP-8 memory arbiter.
//   CH8_ADDR_W / CH8_DATA_W : default RAM geometry (4 KiB x 8)
//   REQ_LOAD / REQ_CPU / REQ_DRAW : requester bit positions
//   arb_state_t : arbiter FSM encoding
package ch8_pkg;

    localparam int CH8_ADDR_W = 12;
    localparam int CH8_DATA_W = 8;

    localparam int REQ_LOAD = 0;
    localparam int REQ_CPU  = 1;
    localparam int REQ_DRAW = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ch8_mem_arbiter.sv
// ch8_mem_arbiter: single-port RAM arbiter for loader, CPU and draw engine.
//   clk, rst_n          : clock, async active-low reset
//   req/lock/we [2:0]   : per-requester strobes ([0]=loader,[1]=CPU,[2]=draw)
//   addr/wdata          : per-requester fields, requester k at [k*W +: W]
//   gnt [2:0]           : combinational one-hot grant
//   rvalid [2:0], rdata : read return, one cycle after the grant
//   ram_*               : RAM command port; ram_rdata has one-cycle latency
//   lock_err            : sticky, set when an idle lock owner is evicted
module ch8_mem_arbiter
    import ch8_pkg::*;
#(
    parameter int ADDR_W  = CH8_ADDR_W,
    parameter int DATA_W  = CH8_DATA_W,
    parameter int LOCK_TO = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic [2:0]            lock,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  lock_err
);

    localparam int CNT_W = $clog2(LOCK_TO + 1);

    arb_state_t         state, state_n;
    logic [1:0]         owner, owner_n;
    logic               rr_draw, rr_draw_n;   // 1: draw wins the next CPU/draw tie
    logic [CNT_W-1:0]   idle_cnt, idle_cnt_n;
    logic               lock_err_n;
    logic [2:0]         gnt_c;
    logic [1:0]         sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= 2'd0;
            rr_draw  <= 1'b0;
            idle_cnt <= '0;
            lock_err <= 1'b0;
            rvalid   <= 3'b000;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_draw  <= rr_draw_n;
            idle_cnt <= idle_cnt_n;
            lock_err <= lock_err_n;
            rvalid   <= gnt_c & ~we;
        end
    end

    always_comb begin
        gnt_c      = 3'b000;
        state_n    = state;
        owner_n    = owner;
        rr_draw_n  = rr_draw;
        idle_cnt_n = idle_cnt;
        lock_err_n = lock_err;
        case (state)
            ST_IDLE: begin
                if (req[REQ_LOAD])
                    gnt_c[REQ_LOAD] = 1'b1;
                else if (req[REQ_CPU] && req[REQ_DRAW])
                    gnt_c[rr_draw ? REQ_DRAW : REQ_CPU] = 1'b1;
                else if (req[REQ_CPU])
                    gnt_c[REQ_CPU] = 1'b1;
                else if (req[REQ_DRAW])
                    gnt_c[REQ_DRAW] = 1'b1;
                if (|(gnt_c & lock)) begin
                    state_n    = ST_LOCKED;
                    owner_n    = sel;
                    idle_cnt_n = '0;
                end
            end
            ST_LOCKED: begin
                if (req[owner]) begin
                    gnt_c[owner] = 1'b1;
                    idle_cnt_n   = '0;
                    if (!lock[owner])
                        state_n = ST_IDLE;
                end else if (idle_cnt == CNT_W'(LOCK_TO - 1)) begin
                    // Owner has been silent LOCK_TO cycles: evict, no grant this cycle.
                    state_n    = ST_IDLE;
                    lock_err_n = 1'b1;
                    idle_cnt_n = '0;
                end else begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Pointer hands the next tie to whichever of CPU/draw was not just served.
        if (gnt_c[REQ_CPU])  rr_draw_n = 1'b1;
        if (gnt_c[REQ_DRAW]) rr_draw_n = 1'b0;
    end

    always_comb begin
        sel = 2'd0;
        if (gnt_c[REQ_CPU])  sel = 2'd1;
        if (gnt_c[REQ_DRAW]) sel = 2'd2;
    end

    always_comb begin
        ram_addr  = addr[0 +: ADDR_W];
        ram_wdata = wdata[0 +: DATA_W];
        case (sel)
            2'd1: begin
                ram_addr  = addr[ADDR_W +: ADDR_W];
                ram_wdata = wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                ram_addr  = addr[2*ADDR_W +: ADDR_W];
                ram_wdata = wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // Outputs are held quiet while reset is asserted even though gnt_c is comb.
    assign gnt    = rst_n ? gnt_c : 3'b000;
    assign ram_en = |gnt;
    assign ram_we = |(gnt & we);
    assign rdata  = ram_rdata;

endmodule
